// File: rtl/fg_pkg.sv
// Shared defaults and helpers for the fault-generator configuration bank.
package fg_pkg;

   localparam int          FG_NUM_REGS    = 8;
   localparam int          FG_REG_WIDTH   = 8;
   localparam int          FG_SYNC_STAGES = 2;
   localparam logic [63:0] FG_RESET_VALUE = 64'h6140_6800_0000_3200;

   function automatic int fg_clog2(input int n);
      int r;
      int v;
      r = 32'sd0;
      v = n - 32'sd1;
      while (v > 32'sd0) begin
         r = r + 32'sd1;
         v = v >>> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fg_sync_cell.sv
// Multi-stage synchronizer for one asynchronous active-low control; idles high.
module fg_sync_cell #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o,
   output logic pre_o
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   // Shift the asynchronous input one stage per clock.
   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d_i};
   end

   // Chain flops; reset to the inactive (high) level.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         chain_q <= {STAGES{1'b1}};
      end else begin
         chain_q <= chain_d;
      end
   end

   // pre_o is the value q_o will take at the next edge.
   assign q_o   = chain_q[STAGES-1];
   assign pre_o = chain_q[STAGES-2];

endmodule

// File: rtl/fg_config_bank.sv
// Double-buffered configuration register bank: writes land in a shadow bank
// and reach the active bank only at generator period boundaries while enabled.
module fg_config_bank
   import fg_pkg::*;
#(
   parameter int                             NUM_REGS    = FG_NUM_REGS,
   parameter int                             REG_WIDTH   = FG_REG_WIDTH,
   parameter int                             SYNC_STAGES = FG_SYNC_STAGES,
   parameter logic [NUM_REGS*REG_WIDTH-1:0]  RESET_VALUE = FG_RESET_VALUE,
   localparam int                            ADDR_WIDTH  =
      (fg_clog2(NUM_REGS) > 1) ? fg_clog2(NUM_REGS) : 1
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic [REG_WIDTH-1:0]          data_i,
   input  logic [ADDR_WIDTH-1:0]         addr_i,
   input  logic                          wr_n_i,
   input  logic                          enable_n_i,
   input  logic                          update_i,
   output logic [NUM_REGS*REG_WIDTH-1:0] cr_bus_o,
   output logic                          enable_o,
   output logic                          pending_o,
   output logic                          commit_o,
   output logic                          wr_err_o
);

   localparam int BUS_W = NUM_REGS * REG_WIDTH;

   logic             wr_n_sync_s;
   logic             wr_pre_unused_s;
   logic             en_n_sync_s;
   logic             en_n_pre_s;
   logic             wr_evt_s;
   logic             addr_ok_s;
   logic             wr_ok_s;
   logic             en_fall_s;

   logic             wr_dly_q,  wr_dly_d;
   logic [BUS_W-1:0] shadow_q,  shadow_d;
   logic [BUS_W-1:0] active_q,  active_d;
   logic             pending_q, pending_d;
   logic             commit_q,  commit_d;
   logic             wr_err_q,  wr_err_d;

   fg_sync_cell #(.STAGES(SYNC_STAGES)) u_wr_sync (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (wr_n_i),
      .q_o    (wr_n_sync_s),
      .pre_o  (wr_pre_unused_s)
   );

   fg_sync_cell #(.STAGES(SYNC_STAGES)) u_en_sync (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (enable_n_i),
      .q_o    (en_n_sync_s),
      .pre_o  (en_n_pre_s)
   );

   // Write-strobe edge detect, address check and enable-drop lookahead.
   always_comb begin
      wr_evt_s  = ~wr_n_sync_s & wr_dly_q;
      addr_ok_s = (32'(addr_i) < 32'(NUM_REGS));
      wr_ok_s   = wr_evt_s & addr_ok_s;
      en_fall_s = enable_o & en_n_pre_s;
   end

   // Next-state for shadow/active banks, pending, commit and error flags.
   always_comb begin
      wr_dly_d = wr_n_sync_s;
      wr_err_d = wr_err_q | (wr_evt_s & ~addr_ok_s);
      for (int i = 0; i < NUM_REGS; i++) begin
         shadow_d[(NUM_REGS-1-i)*REG_WIDTH +: REG_WIDTH] =
            (wr_ok_s && (addr_i == ADDR_WIDTH'(i))) ? data_i
                                                    : shadow_q[(NUM_REGS-1-i)*REG_WIDTH +: REG_WIDTH];
      end
      active_d  = active_q;
      pending_d = pending_q;
      commit_d  = 1'b0;
      if (!enable_o) begin
         active_d  = shadow_d;
         pending_d = 1'b0;
      end else if (en_fall_s && (pending_q || wr_ok_s)) begin
         // Generator is stopping: flush everything outstanding, including this write.
         active_d  = shadow_d;
         pending_d = 1'b0;
         commit_d  = 1'b1;
      end else if (update_i && pending_q) begin
         // A coincident write stays in shadow for the next boundary.
         active_d  = shadow_q;
         pending_d = wr_ok_s;
         commit_d  = 1'b1;
      end else begin
         pending_d = pending_q | wr_ok_s;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_dly_q  <= 1'b1;
         shadow_q  <= RESET_VALUE;
         active_q  <= RESET_VALUE;
         pending_q <= 1'b0;
         commit_q  <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         wr_dly_q  <= wr_dly_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         commit_q  <= commit_d;
         wr_err_q  <= wr_err_d;
      end
   end

   assign cr_bus_o  = active_q;
   assign enable_o  = ~en_n_sync_s;
   assign pending_o = pending_q;
   assign commit_o  = commit_q;
   assign wr_err_o  = wr_err_q;

endmodule
